apb_requester: RTL and testbench

- APB3 requester (master) that drives the 8-bit timer's APB completer port, replacing the bench CPU task in hardware.
- Accepts single read/write commands on a valid/ready interface and runs the SETUP/ACCESS phases.
- Waits on PREADY, bounded by a timeout.
- Returns read data and error status as a one-cycle response pulse.

---
 rtl/apb_pkg.sv | 25 ++
 rtl/apb_wait_timer.sv | 49 ++++
 rtl/apb_requester.sv | 147 ++++++++++++++
 tb/tb_apb_requester.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester definitions: FSM states, default widths and the
// timer completer's register map.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   // 8-bit timer completer register addresses
   localparam logic [7:0] REG_CTRL  = 8'h00;
   localparam logic [7:0] REG_LOAD  = 8'h01;
   localparam logic [7:0] REG_CMP   = 8'h02;
   localparam logic [7:0] REG_COUNT = 8'h03;

   // Wait counter width; a disabled timeout still needs a 1-bit counter.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: cleared when a transfer is launched, counts
// stalled cycles, flags expiry on the last allowed stalled cycle.
module apb_wait_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_limit;

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign at_limit = 1'b0;
      end else begin : g_timeout
         assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));
      end
   endgenerate

   assign expired = en && at_limit;

   // Saturate rather than wrap so a disabled timeout never aliases.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_requester.sv
// APB3 requester: takes single read/write commands, runs SETUP/ACCESS,
// waits on PREADY with a bounded timeout and returns a one-cycle response.
module apb_requester
   import apb_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   apb_state_e        state_q, state_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   logic              launch;
   logic              stall;
   logic              expired;

   assign cmd_ready = (state_q == ST_IDLE);
   assign launch    = cmd_valid && cmd_ready;
   assign stall     = (state_q == ST_ACCESS) && !PREADY;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clr     (launch),
      .en      (stall),
      .expired (expired)
   );

   // Response fields are only meaningful with rsp_valid; they return to 0 otherwise.
   always_comb begin
      state_d       = state_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = '0;
      rsp_err_d     = 1'b0;
      rsp_timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (launch) begin
               pwrite_d = cmd_write;
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               psel_d   = 1'b1;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            penable_d = 1'b1;
            state_d   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : PRDATA;
               rsp_err_d   = PSLVERR;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               state_d     = ST_IDLE;
            end else if (expired) begin
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q       <= ST_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign PSEL        = psel_q;
   assign PENABLE     = penable_q;
   assign PWRITE      = pwrite_q;
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: randomized commands against a
// behavioural completer; a negedge monitor checks every cycle of each transfer.
module tb_apb_requester;
   import apb_pkg::*;

   localparam int TO = 4;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_err, rsp_timeout;
   logic [7:0] rsp_rdata;
   logic       PSEL, PENABLE, PWRITE;
   logic [7:0] PADDR, PWDATA, PRDATA;
   logic       PREADY, PSLVERR;

   apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      int         acc;     // cycle in which the command is accepted
      int         rsp_ph;  // cycles from acceptance to the response
      bit         w;
      logic [7:0] a, d, rdata;
      bit         err, to;
   } exp_t;

   exp_t q[$];
   int   total = 0, bad = 0;
   int   cyc = 0;
   bit   mon_en = 0;
   int   prev_rsp_cyc = -1;

   // completer plan for the transfer in flight
   int         plan_wait = 0;
   bit         plan_err = 0;
   logic [7:0] plan_rdata = 8'h00;
   int         acc_cnt = 0;

   always @(posedge PCLK) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Completer: PREADY rises on ACCESS cycle plan_wait; junk elsewhere must be ignored.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         PREADY  = (acc_cnt == plan_wait);
         PSLVERR = PREADY ? plan_err : 1'($urandom_range(0, 1));
         PRDATA  = PREADY ? plan_rdata : 8'($urandom);
         acc_cnt++;
      end else begin
         acc_cnt = 0;
         PREADY  = 1'($urandom_range(0, 1));
         PSLVERR = 1'($urandom_range(0, 1));
         PRDATA  = 8'($urandom);
      end
   end

   // Monitor: cycle-accurate check of the transfer at the head of the scoreboard.
   always @(negedge PCLK) begin
      if (mon_en && PRESETn) begin
         if (q.size() > 0 && cyc > q[0].acc) begin
            exp_t e;
            int   ph;
            e  = q[0];
            ph = cyc - e.acc;
            if (ph < e.rsp_ph) begin
               chk("psel_busy", PSEL, 1);
               chk("penable_phase", PENABLE, (ph >= 2));
               chk("paddr_stable", PADDR, e.a);
               chk("pwrite_stable", PWRITE, e.w);
               if (e.w) chk("pwdata_stable", PWDATA, e.d);
               chk("rsp_valid_early", rsp_valid, 0);
               chk("cmd_ready_busy", cmd_ready, 0);
            end else begin
               chk("rsp_valid", rsp_valid, 1);
               chk("rsp_rdata", rsp_rdata, e.rdata);
               chk("rsp_err", rsp_err, e.err);
               chk("rsp_timeout", rsp_timeout, e.to);
               chk("psel_after", PSEL, 0);
               chk("penable_after", PENABLE, 0);
               chk("cmd_ready_after", cmd_ready, 1);
               void'(q.pop_front());
            end
         end else begin
            chk("rsp_valid_idle", rsp_valid, 0);
            chk("psel_idle", PSEL, 0);
            chk("cmd_ready_idle", cmd_ready, 1);
         end
      end
   end

   task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d,
                        input int wt, input bit er, input logic [7:0] rd, input bit b2b);
      int   guard;
      exp_t e;
      bit   tmo;
      guard = 0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && guard < 60) begin
         @(negedge PCLK);
         guard++;
      end
      if (!cmd_ready) begin
         chk("cmd_accept_bound", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end
      if (b2b) chk("b2b_start_cycle", cyc, prev_rsp_cyc);
      plan_wait  = wt;
      plan_err   = er;
      plan_rdata = rd;
      tmo        = (wt >= TO);
      e.acc      = cyc;
      e.rsp_ph   = 2 + (tmo ? TO : wt + 1);
      e.w        = w;
      e.a        = a;
      e.d        = d;
      e.rdata    = (tmo || w) ? 8'h00 : rd;
      e.err      = tmo ? 1'b1 : er;
      e.to       = tmo;
      q.push_back(e);
      prev_rsp_cyc = e.acc + e.rsp_ph;
      @(posedge PCLK);
   endtask

   task automatic idle_cycles(input int n);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      repeat (n) @(negedge PCLK);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      while (q.size() > 0 && guard < 100) begin
         @(negedge PCLK);
         guard++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] addrs [4];
      bit         held;
      int         r, wt, gap;
      addrs[0] = REG_CTRL; addrs[1] = REG_LOAD; addrs[2] = REG_CMP; addrs[3] = REG_COUNT;

      PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      #1;
      chk("reset_cmd_ready", cmd_ready, 1);
      chk("reset_psel", PSEL, 0);
      chk("reset_penable", PENABLE, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_paddr", PADDR, 0);
      repeat (3) @(negedge PCLK);
      PRESETn = 1'b1;
      mon_en  = 1'b1;

      // zero-wait write, wait-state read, slave error then a normal read
      issue(1, REG_LOAD, 8'hA5, 0, 0, 8'h00, 0); idle_cycles(2);
      issue(0, REG_COUNT, 8'h00, 3, 0, 8'h5C, 0); idle_cycles(2);
      issue(1, REG_CMP, 8'h3C, 0, 1, 8'h00, 0); idle_cycles(1);
      issue(0, REG_CTRL, 8'h00, 0, 0, 8'h81, 0); idle_cycles(2);
      // timeout with PREADY held low, and the last in-bound wait
      issue(0, REG_CTRL, 8'h00, 99, 0, 8'hEE, 0); idle_cycles(1);
      issue(0, REG_CMP, 8'h00, TO - 1, 0, 8'h77, 0); idle_cycles(1);
      // back-to-back with cmd_valid held
      issue(1, REG_CTRL, 8'h11, 0, 0, 8'h00, 0);
      issue(1, REG_LOAD, 8'h22, 1, 0, 8'h00, 1);
      issue(0, REG_COUNT, 8'h00, 0, 0, 8'h33, 1);
      idle_cycles(2);

      held = 0;
      for (int i = 0; i < 150; i++) begin
         r   = $urandom_range(0, 9);
         wt  = (r < 7) ? $urandom_range(0, TO - 1) : $urandom_range(TO, TO + 4);
         issue(1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) != 0) ? addrs[$urandom_range(0, 3)] : 8'($urandom),
               8'($urandom), wt, ($urandom_range(0, 3) == 0), 8'($urandom), held);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle_cycles(gap - 1);
         held = (gap == 0);
      end
      drain();

      // reset while PENABLE is high: outputs drop without a clock edge
      mon_en = 1'b0;
      issue(0, REG_COUNT, 8'h00, 50, 0, 8'h99, 0);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      @(negedge PCLK);
      chk("mid_penable_before", PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_psel_async", PSEL, 0);
      chk("mid_penable_async", PENABLE, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      q.delete();
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge PCLK);
         chk("post_reset_rsp_valid", rsp_valid, 0);
         chk("post_reset_psel", PSEL, 0);
         chk("post_reset_cmd_ready", cmd_ready, 1);
      end
      mon_en = 1'b1;
      issue(0, REG_LOAD, 8'h00, 1, 0, 8'h4B, 0);
      issue(1, REG_CTRL, 8'hC3, 0, 1, 8'h00, 1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
